// File: rtl/motor_drive_pkg.sv
// Shared types, widths and duty arithmetic helper for the motor_drive PWM stage.
package motor_drive_pkg;

  typedef enum logic [1:0] {IDLE, RAMP, RUN, LOST} state_t;

  localparam int unsigned PID_W       = 11;
  localparam int unsigned PID_CENTER  = 500;
  localparam int unsigned PID_INVALID = 0;
  localparam int unsigned C_W         = 12;
  localparam int unsigned RAW_W       = 13;
  localparam int unsigned DUTY_W      = 11;

  // Clamp a signed raw duty to [0, max_duty], then limit it by the ramp cap.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic signed [RAW_W-1:0] raw,
                                                   input logic [DUTY_W-1:0] max_duty,
                                                   input logic [DUTY_W-1:0] cap);
    logic [DUTY_W-1:0] v;
    if (raw[RAW_W-1])
      v = '0;
    else if (raw > $signed({2'b00, max_duty}))
      v = max_duty;
    else
      v = DUTY_W'(raw);
    return (v < cap) ? v : cap;
  endfunction

endpackage

// File: rtl/motor_drive_if.sv
// Control/status bundle between the PID side and the motor_drive PWM stage.
interface motor_drive_if;
  import motor_drive_pkg::*;

  logic              enable;
  logic [PID_W-1:0]  pid_in;
  logic              pwm_left;
  logic              pwm_right;
  logic [DUTY_W-1:0] duty_left;
  logic [DUTY_W-1:0] duty_right;
  logic              frame_start;
  logic              lost;

  modport master (output enable, pid_in,
                  input  pwm_left, pwm_right, duty_left, duty_right, frame_start, lost);
  modport slave  (input  enable, pid_in,
                  output pwm_left, pwm_right, duty_left, duty_right, frame_start, lost);
endinterface

// File: rtl/motor_drive_pwm_timebase.sv
// Prescaler plus frame counter; tick advances cnt, wrap marks the last tick of a frame.
module pwm_timebase #(
  parameter  int unsigned PRESCALE   = 10,
  parameter  int unsigned PWM_PERIOD = 1000,
  localparam int unsigned PS_W       = $clog2(PRESCALE + 1),
  localparam int unsigned CNT_W      = $clog2(PWM_PERIOD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick,
  output logic             wrap,
  output logic [CNT_W-1:0] cnt
);

  logic [PS_W-1:0] presc;

  assign tick = (presc == PS_W'(PRESCALE - 1));
  assign wrap = tick && (cnt == CNT_W'(PWM_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
      cnt   <= '0;
    end else begin
      presc <= tick ? '0 : presc + PS_W'(1);
      if (tick) cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/motor_drive.sv
// Differential-drive PWM stage: PID output -> wheel duties with soft start and lost-line handling.
// Define MOTOR_DRIVE_RAMP_EN to build the soft-start RAMP state; otherwise the cap is fixed at MAX_DUTY.
module motor_drive
  import motor_drive_pkg::*;
#(
  parameter int unsigned PRESCALE    = 10,
  parameter int unsigned PWM_PERIOD  = 1000,
  parameter int unsigned BASE_DUTY   = 600,
  parameter int unsigned MAX_DUTY    = 1000,
  parameter int unsigned RAMP_STEP   = 250,
  parameter int unsigned LOST_FRAMES = 3
) (
  input  logic         clk,
  input  logic         rst,
  motor_drive_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(PWM_PERIOD + 1);
  localparam int unsigned LC_W  = $clog2(LOST_FRAMES + 1);

  if (PRESCALE == 0 || MAX_DUTY > PWM_PERIOD || RAMP_STEP == 0 || LOST_FRAMES == 0) begin : g_bad_cfg
    $error("motor_drive: invalid parameter set");
  end

  logic             tick, wrap, frame_edge;
  logic [CNT_W-1:0] cnt;

  pwm_timebase #(.PRESCALE(PRESCALE), .PWM_PERIOD(PWM_PERIOD)) u_timebase (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .wrap (wrap),
    .cnt  (cnt)
  );

  assign frame_edge = wrap & tick;

  state_t            state, state_nx, enter_state;
  logic [DUTY_W-1:0] duty_l, duty_r, duty_l_nx, duty_r_nx, cap_step;
  logic [LC_W-1:0]   lost_cnt, lost_cnt_nx, lost_cnt_inc;
  logic              pwm_l, pwm_r, frame_start, lost;
  logic              pid_valid, lost_hit, tracking;
  logic signed [C_W-1:0]   c;
  logic signed [RAW_W-1:0] raw_l, raw_r;

  assign pid_valid    = (bus.pid_in != PID_W'(PID_INVALID));
  assign c            = $signed({1'b0, bus.pid_in}) - $signed(C_W'(PID_CENTER));
  assign raw_l        = $signed(RAW_W'(BASE_DUTY)) + $signed({c[C_W-1], c});
  assign raw_r        = $signed(RAW_W'(BASE_DUTY)) - $signed({c[C_W-1], c});
  assign lost_cnt_inc = lost_cnt + LC_W'(1);
  assign lost_hit     = (lost_cnt_inc == LC_W'(LOST_FRAMES));
  assign tracking     = (state == RAMP) || (state == RUN);

`ifdef MOTOR_DRIVE_RAMP_EN
  // IDLE and LOST restart the ramp from zero; RUN keeps cap at MAX_DUTY.
  logic [DUTY_W-1:0] cap, cap_base;
  logic [DUTY_W:0]   cap_sum;

  assign cap_base    = tracking ? cap : '0;
  assign cap_sum     = {1'b0, cap_base} + (DUTY_W + 1)'(RAMP_STEP);
  assign cap_step    = (cap_sum >= (DUTY_W + 1)'(MAX_DUTY)) ? DUTY_W'(MAX_DUTY) : cap_sum[DUTY_W-1:0];
  assign enter_state = (cap_step == DUTY_W'(MAX_DUTY)) ? RUN : RAMP;

  always_ff @(posedge clk) begin
    if (!rst || !bus.enable) cap <= '0;
    else if (frame_edge && pid_valid) cap <= cap_step;
  end
`else
  assign cap_step    = DUTY_W'(MAX_DUTY);
  assign enter_state = RUN;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!bus.enable)
      state_nx = IDLE;
    else if (frame_edge) begin
      if (pid_valid)
        state_nx = enter_state;
      else if (tracking && lost_hit)
        state_nx = LOST;
    end
  end

  // Next duty/lost-counter values; invalid samples hold duties until LOST is reached.
  always_comb begin
    duty_l_nx   = duty_l;
    duty_r_nx   = duty_r;
    lost_cnt_nx = lost_cnt;
    if (!bus.enable) begin
      duty_l_nx   = '0;
      duty_r_nx   = '0;
      lost_cnt_nx = '0;
    end else if (frame_edge) begin
      if (pid_valid) begin
        duty_l_nx   = clamp_duty(raw_l, DUTY_W'(MAX_DUTY), cap_step);
        duty_r_nx   = clamp_duty(raw_r, DUTY_W'(MAX_DUTY), cap_step);
        lost_cnt_nx = '0;
      end else if (tracking) begin
        if (lost_hit) begin
          duty_l_nx   = '0;
          duty_r_nx   = '0;
          lost_cnt_nx = '0;
        end else begin
          lost_cnt_nx = lost_cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      duty_l      <= '0;
      duty_r      <= '0;
      lost_cnt    <= '0;
      pwm_l       <= 1'b0;
      pwm_r       <= 1'b0;
      frame_start <= 1'b0;
      lost        <= 1'b0;
    end else begin
      duty_l      <= duty_l_nx;
      duty_r      <= duty_r_nx;
      lost_cnt    <= lost_cnt_nx;
      pwm_l       <= (DUTY_W'(cnt) < duty_l);
      pwm_r       <= (DUTY_W'(cnt) < duty_r);
      frame_start <= frame_edge;
      lost        <= (state_nx == LOST);
    end
  end

  assign bus.duty_left   = duty_l;
  assign bus.duty_right  = duty_r;
  assign bus.pwm_left    = pwm_l;
  assign bus.pwm_right   = pwm_r;
  assign bus.frame_start = frame_start;
  assign bus.lost        = lost;

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive with PRESCALE=1; expectations follow MOTOR_DRIVE_RAMP_EN.
module tb_motor_drive;
  import motor_drive_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  motor_drive_if bus ();

  motor_drive #(
    .PRESCALE(1), .PWM_PERIOD(1000), .BASE_DUTY(600),
    .MAX_DUTY(1000), .RAMP_STEP(250), .LOST_FRAMES(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef MOTOR_DRIVE_RAMP_EN
  localparam int RAMP_D[4]  = '{250, 500, 600, 600};
  localparam int RAMP_ST[4] = '{int'(RAMP), int'(RAMP), int'(RAMP), int'(RUN)};
`else
  localparam int RAMP_D[4]  = '{600, 600, 600, 600};
  localparam int RAMP_ST[4] = '{int'(RUN), int'(RUN), int'(RUN), int'(RUN)};
`endif

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next negedge on which frame_start is high.
  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (!bus.frame_start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.frame_start) check("frame_timeout", 0, 1);
  endtask

  // Count PWM high cycles over the frame following the current frame_start.
  task automatic count_pwm(output int l, output int r);
    l = 0;
    r = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      l += int'(bus.pwm_left);
      r += int'(bus.pwm_right);
    end
  endtask

  initial begin
    int n, pl, pr;
    int steer_pid[3] = '{800, 1000, 1};
    int steer_l[3]   = '{900, 1000, 101};
    int steer_r[3]   = '{300, 100, 1000};

    rst = 1'b0;
    bus.enable = 1'b1;
    bus.pid_in = 11'd500;
    repeat (5) @(negedge clk);
    check("rst_duty_l", int'(bus.duty_left), 0);
    check("rst_duty_r", int'(bus.duty_right), 0);
    check("rst_pwm_l", int'(bus.pwm_left), 0);
    check("rst_pwm_r", int'(bus.pwm_right), 0);
    check("rst_frame_start", int'(bus.frame_start), 0);
    check("rst_lost", int'(bus.lost), 0);
    check("rst_cnt", int'(dut.u_timebase.cnt), 0);

    rst = 1'b1;
    n = 0;
    while (!bus.frame_start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("first_frame_delay", n, 1000);

    // Soft start at centred input
    for (int f = 0; f < 4; f++) begin
      if (f != 0) wait_frame();
      check($sformatf("ramp%0d_l", f), int'(bus.duty_left), RAMP_D[f]);
      check($sformatf("ramp%0d_r", f), int'(bus.duty_right), RAMP_D[f]);
      check($sformatf("ramp%0d_state", f), int'(dut.state), RAMP_ST[f]);
    end
    count_pwm(pl, pr);
    check("pwm_l_600", pl, 600);
    check("pwm_r_600", pr, 600);

    // Steering and clamping in RUN
    for (int s = 0; s < 3; s++) begin
      bus.pid_in = 11'(steer_pid[s]);
      wait_frame();
      check($sformatf("steer%0d_l", s), int'(bus.duty_left), steer_l[s]);
      check($sformatf("steer%0d_r", s), int'(bus.duty_right), steer_r[s]);
      count_pwm(pl, pr);
      check($sformatf("steer%0d_pwm_l", s), pl, steer_l[s]);
      check($sformatf("steer%0d_pwm_r", s), pr, steer_r[s]);
    end

    // Lost line
    bus.pid_in = 11'd500;
    wait_frame();
    check("pre_lost_l", int'(bus.duty_left), 600);
    bus.pid_in = 11'd0;
    for (int f = 0; f < 2; f++) begin
      wait_frame();
      check($sformatf("hold%0d_l", f), int'(bus.duty_left), 600);
      check($sformatf("hold%0d_r", f), int'(bus.duty_right), 600);
      check($sformatf("hold%0d_lost", f), int'(bus.lost), 0);
    end
    wait_frame();
    check("lost_duty_l", int'(bus.duty_left), 0);
    check("lost_duty_r", int'(bus.duty_right), 0);
    check("lost_flag", int'(bus.lost), 1);
    check("lost_state", int'(dut.state), int'(LOST));
    count_pwm(pl, pr);
    check("lost_pwm_l", pl, 0);
    check("lost_pwm_r", pr, 0);
    bus.pid_in = 11'd500;
    wait_frame();
    check("recover_lost", int'(bus.lost), 0);
    check("recover_l", int'(bus.duty_left), RAMP_D[0]);
    check("recover_r", int'(bus.duty_right), RAMP_D[0]);
    repeat (3) wait_frame();
    check("rerun_state", int'(dut.state), int'(RUN));
    check("rerun_l", int'(bus.duty_left), 600);

    // Enable drop mid-frame
    repeat (400) @(negedge clk);
    check("drop_cnt", int'(dut.u_timebase.cnt), 400);
    bus.enable = 1'b0;
    @(negedge clk);
    check("drop_duty_l", int'(bus.duty_left), 0);
    check("drop_duty_r", int'(bus.duty_right), 0);
    check("drop_state", int'(dut.state), int'(IDLE));
    @(negedge clk);
    check("drop_pwm_l", int'(bus.pwm_left), 0);
    check("drop_pwm_r", int'(bus.pwm_right), 0);
    bus.enable = 1'b1;
    wait_frame();
    check("reenable_l", int'(bus.duty_left), RAMP_D[0]);
    check("reenable_state", int'(dut.state), RAMP_ST[0]);

    // Reset mid-frame
    repeat (300) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_duty_l", int'(bus.duty_left), 0);
    check("midrst_cnt", int'(dut.u_timebase.cnt), 0);
    check("midrst_state", int'(dut.state), int'(IDLE));
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
